wb_port_arbiter: RTL

//  Shares the single register-file write port between the in-order pipeline writeback (MEM/WB outputs)
//  and a multi-cycle execution unit (mul/div) using a valid/ready handshake.
//  The pipeline has priority. A starvation timer forces a one-cycle pipeline bubble so the MC unit progresses.

---
 rtl/wb_arb_pkg.sv | 28 ++
 rtl/wb_starve_timer.sv | 37 +++
 rtl/wb_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   - Default widths and starvation limit used by wb_port_arbiter.
//   - arbStateE: arbitration FSM states (ARB, STALL, BUBBLE).
//   - grantSrcE: which requester owns the write port in a cycle.
//   - waitCntWidth(): width of the saturating starvation counter.
package wb_arb_pkg;

  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    STALL  = 2'd1,
    BUBBLE = 2'd2
  } arbStateE;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_PIPE = 2'd1,
    G_MC   = 2'd2
  } grantSrcE;

  function automatic int waitCntWidth(input int starveMax);
    return $clog2(starveMax) + 1;
  endfunction

endpackage

// File: rtl/wb_starve_timer.sv
// Saturating count of consecutive arbitration cycles the multi-cycle unit lost.
// Ports:
//   Clock    in   rising-edge clock
//   Reset_n  in   synchronous active-low reset
//   Inc      in   MC lost arbitration this cycle
//   Clr      in   restart the count (wins over Inc)
//   Expire   out  this increment reaches STARVE_MAX-1 (combinational)
//   Count    out  current count, saturates at STARVE_MAX-1
module wb_starve_timer #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX) + 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Inc,
  input  logic             Clr,
  output logic             Expire,
  output logic [CNT_W-1:0] Count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX - 1);

  // One extra bit so the compare works even when Count sits at the top value.
  logic [CNT_W:0] countPlus;

  assign countPlus = {1'b0, Count} + (CNT_W + 1)'(1);
  assign Expire    = Inc && (countPlus >= {1'b0, CNT_MAX});

  always_ff @(posedge Clock) begin
    if (!Reset_n || Clr) begin
      Count <= '0;
    end else if (Inc && (Count != CNT_MAX)) begin
      Count <= Count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback
// (priority) and a multi-cycle mul/div unit. A starvation timer forces a
// one-cycle pipeline bubble so the MC unit always makes progress.
//
// Handshake: the MC unit holds MCValid with a stable payload until it sees
// MCReady=1 in the same cycle; MCReady marks the request as consumed, either
// written to the register file or squashed by a younger pipeline write to
// the same register.
//
// Ports:
//   Clock, Reset_n                      clock, synchronous active-low reset
//   RegWriteIn/WriteRegisterIn/ALUResultIn  pipeline writeback request
//   MCValid/MCWriteRegister/MCResult    MC unit request
//   MCReady          out  comb   MC request consumed this cycle
//   StallPipe        out  reg    pipeline must not write next cycle
//   RFWriteEnable/RFWriteRegister/RFWriteData  out reg  register-file write
//   ProtocolErr      out  reg    sticky: pipeline wrote during a forced bubble
//   ForcedBubbleCnt, SquashCnt   out reg  only with WB_PERF_CNT_EN defined
//   DbgState         out  reg    current FSM state
//
// Configuration: define WB_PERF_CNT_EN to add the wrapping performance
// counters ForcedBubbleCnt and SquashCnt.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              RegWriteIn,
  input  logic [ADDR_W-1:0] WriteRegisterIn,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic              MCValid,
  input  logic [ADDR_W-1:0] MCWriteRegister,
  input  logic [DATA_W-1:0] MCResult,
  output logic              MCReady,
  output logic              StallPipe,
  output logic              RFWriteEnable,
  output logic [ADDR_W-1:0] RFWriteRegister,
  output logic [DATA_W-1:0] RFWriteData,
  output logic              ProtocolErr,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]       ForcedBubbleCnt,
  output logic [31:0]       SquashCnt,
`endif
  output logic [1:0]        DbgState
);

  localparam int         WAIT_W   = waitCntWidth(STARVE_MAX);
  localparam logic [1:0] S_ARB    = ARB;
  localparam logic [1:0] S_STALL  = STALL;
  localparam logic [1:0] S_BUBBLE = BUBBLE;

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic              stallNext;
  grantSrcE          grant;
  logic              squash;
  logic              mcDropped;
  logic              mcValidQ;
  logic              mcReadyQ;
  logic              timerInc;
  logic              timerClr;
  logic              timerExpire;
  logic [WAIT_W-1:0] waitCnt;

  always_comb begin
    // Same destination: the MC result is older, so the pipeline write
    // supersedes it and the MC request is retired without writing.
    squash    = RegWriteIn && MCValid && (WriteRegisterIn == MCWriteRegister);
    // MC withdrew a request it was never granted.
    mcDropped = mcValidQ && !mcReadyQ && !MCValid;
    grant     = G_NONE;
    if (RegWriteIn) begin
      grant = G_PIPE;
    end else if (MCValid) begin
      grant = G_MC;
    end
  end

  assign MCReady = Reset_n && (squash || (grant == G_MC));

  // Only losses in ARB count toward starvation; STALL is already committed.
  assign timerInc = (state == S_ARB) && RegWriteIn && MCValid && !squash;
  assign timerClr = (state == S_BUBBLE) || MCReady || mcDropped;

  wb_starve_timer #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (WAIT_W)
  ) u_starve_timer (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Inc     (timerInc),
    .Clr     (timerClr),
    .Expire  (timerExpire),
    .Count   (waitCnt)
  );

  always_comb begin
    stateNext = state;
    stallNext = 1'b0;
    case (state)
      S_ARB: begin
        if (timerExpire) begin
          stateNext = S_STALL;
          stallNext = 1'b1;
        end
      end
      // If the MC unit walks away, the bubble has no one to serve.
      S_STALL:  stateNext = mcDropped ? S_ARB : S_BUBBLE;
      S_BUBBLE: stateNext = S_ARB;
      default:  stateNext = S_ARB;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state           <= S_ARB;
      StallPipe       <= 1'b0;
      mcValidQ        <= 1'b0;
      mcReadyQ        <= 1'b0;
      RFWriteEnable   <= 1'b0;
      RFWriteRegister <= '0;
      RFWriteData     <= '0;
      ProtocolErr     <= 1'b0;
    end else begin
      state         <= stateNext;
      StallPipe     <= stallNext;
      mcValidQ      <= MCValid;
      mcReadyQ      <= MCReady;
      RFWriteEnable <= (grant != G_NONE);
      case (grant)
        G_PIPE: begin
          RFWriteRegister <= WriteRegisterIn;
          RFWriteData     <= ALUResultIn;
        end
        G_MC: begin
          RFWriteRegister <= MCWriteRegister;
          RFWriteData     <= MCResult;
        end
        default: begin
          RFWriteRegister <= '0;
          RFWriteData     <= '0;
        end
      endcase
      if ((state == S_BUBBLE) && RegWriteIn) begin
        ProtocolErr <= 1'b1;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ForcedBubbleCnt <= '0;
      SquashCnt       <= '0;
    end else begin
      if ((state == S_ARB) && timerExpire) begin
        ForcedBubbleCnt <= ForcedBubbleCnt + 32'd1;
      end
      if (squash) begin
        SquashCnt <= SquashCnt + 32'd1;
      end
    end
  end
`endif

  assign DbgState = state;

endmodule
